uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART RX path. It detects the start bit on an oversampled serial line, owns the per-bit edge/bit counters, majority-samples each bit, deserializes the data LSB-first and checks parity and stop. It delivers one `P_DATA` word per good frame with a single-cycle `data_valid` strobe. It sits between the RX pad synchronizer and the register/FIFO consumer.

---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/uart_rx_sampler.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 117 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared states, parity constants and sampling offsets for the UART RX path
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    localparam int SMP_EARLY = -1;
    localparam int SMP_MID = 0;
    localparam int SMP_LATE = 1;
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: three-tap capture around mid-bit plus 2-of-3 majority vote
module uart_rx_sampler import uart_rx_pkg::*; (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_i,
    input  logic [5:0] edge_cnt_i,
    input  logic [5:0] prescale_i,
    output logic       bit_o
);
    logic [5:0] half;
    logic [2:0] tap_q;
    assign half = prescale_i >> 1;
    // Capture the line one cycle before, at and after the bit centre
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tap_q <= '0;
        end else begin
            if (edge_cnt_i == 6'(int'(half) + SMP_EARLY)) tap_q[0] <= rx_i;
            if (edge_cnt_i == 6'(int'(half) + SMP_MID)) tap_q[1] <= rx_i;
            if (edge_cnt_i == 6'(int'(half) + SMP_LATE)) tap_q[2] <= rx_i;
        end
    end
    assign bit_o = maj3(tap_q);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start detection, bit timing, deserialization and parity/stop checking
module uart_rx_ctrl import uart_rx_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    rx_state_e             state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  valid_q, valid_d;
    logic                  smp, bit_end, cnt_en;

    uart_rx_sampler u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .rx_i       (RX_IN),
        .edge_cnt_i (edge_q),
        .prescale_i (Prescale),
        .bit_o      (smp)
    );

    assign cnt_en = (state_q != IDLE) || !RX_IN;
    assign bit_end = edge_q == Prescale - 6'd1;

    // Frame sequencing, shifting and error/result capture at each bit end
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d = data_q;
        valid_d = 1'b0;
        par_en_d = par_en_q;
        par_typ_d = par_typ_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        case (state_q)
            IDLE: if (!RX_IN) begin
                state_d = START;
                par_en_d = PAR_EN;
                par_typ_d = PAR_TYP;
                par_err_d = 1'b0;
                stp_err_d = 1'b0;
            end
            START: if (bit_end) state_d = smp ? IDLE : DATA;
            DATA: if (bit_end) begin
                shift_d = {smp, shift_q[DATA_WIDTH-1:1]};
                if (bit_q == 4'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (bit_end) begin
                par_err_d = smp != ((^shift_q) ^ (par_typ_q == PAR_ODD));
                state_d = STOP;
            end
            STOP: if (bit_end) begin
                stp_err_d = !smp;
                state_d = IDLE;
                if (smp && !par_err_q) begin
                    data_d = shift_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge/bit counters; both clear whenever the frame is not running or is ending
    always_comb begin
        edge_d = '0;
        bit_d = '0;
        if (cnt_en && !(bit_end && state_d == IDLE)) begin
            edge_d = bit_end ? 6'd0 : edge_q + 6'd1;
            bit_d = bit_end ? bit_q + 4'd1 : bit_q;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            edge_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            par_en_q <= 1'b0;
            par_typ_q <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q <= edge_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            data_q <= data_d;
            valid_q <= valid_d;
            par_en_q <= par_en_d;
            par_typ_q <= par_typ_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign P_DATA = data_q;
    assign data_valid = valid_q;
    assign par_err = par_err_q;
    assign stp_err = stp_err_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized frame streams checked against a frame-level model
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         RX_IN = 1'b1;
    logic [5:0]   Prescale = 6'd8;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic [W-1:0] P_DATA;
    logic         data_valid, par_err, stp_err;

    int total = 0;
    int bad = 0;
    logic [W-1:0] m_pdata = '0;
    logic m_par = 1'b0;
    logic m_stp = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        bit pe;
        bit pt;
        bit pbit;
        bit sbit;
        int gap;
        int glitch;
    } frame_t;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    function automatic frame_t good(input logic [W-1:0] d, input bit pe, input bit pt, input int gap);
        frame_t f;
        f.d = d;
        f.pe = pe;
        f.pt = pt;
        f.pbit = (^d) ^ pt;
        f.sbit = 1'b1;
        f.gap = gap;
        f.glitch = 0;
        return f;
    endfunction

    // Serialize a stream of frames at prescale p and compare every cycle with the frame model.
    // Cycle c of a frame is the c-th clock counted from the first low line cycle; events land
    // at start+1 (flags clear), start+p*(W+2) (parity result), start+F (stop result / strobe).
    task automatic run(input int p, input frame_t fq[$]);
        bit line[$];
        bit pea[$];
        bit pta[$];
        bit ev_clr[int];
        bit ev_par[int];
        bit ev_stp[int];
        logic [W-1:0] ev_val[int];
        int s;
        bit exp_v;
        s = 0;
        Prescale = 6'(p);
        foreach (fq[i]) begin
            frame_t f;
            bit fb[$];
            bit perr;
            f = fq[i];
            ev_clr[s + 1] = 1'b1;
            if (f.glitch > 0) begin
                for (int k = 0; k < p; k++) fb.push_back(k < f.glitch ? 1'b0 : 1'b1);
                foreach (fb[k]) begin
                    line.push_back(fb[k]);
                    pea.push_back(1'($urandom_range(1)));
                    pta.push_back(1'($urandom_range(1)));
                end
            end else begin
                fb.push_back(1'b0);
                for (int j = 0; j < W; j++) fb.push_back(f.d[j]);
                if (f.pe) fb.push_back(f.pbit);
                fb.push_back(f.sbit);
                foreach (fb[j]) for (int k = 0; k < p; k++) begin
                    line.push_back(fb[j]);
                    pea.push_back((j == 0 && k == 0) ? f.pe : 1'($urandom_range(1)));
                    pta.push_back((j == 0 && k == 0) ? f.pt : 1'($urandom_range(1)));
                end
                perr = f.pe && (f.pbit != ((^f.d) ^ f.pt));
                if (f.pe) ev_par[s + p * (W + 2)] = perr;
                ev_stp[s + p * fb.size()] = !f.sbit;
                if (f.sbit && !perr) ev_val[s + p * fb.size()] = f.d;
            end
            for (int k = 0; k < f.gap; k++) begin
                line.push_back(1'b1);
                pea.push_back(1'($urandom_range(1)));
                pta.push_back(1'($urandom_range(1)));
            end
            s = line.size();
        end
        for (int k = 0; k < 3; k++) begin
            line.push_back(1'b1);
            pea.push_back(1'b0);
            pta.push_back(1'b0);
        end
        for (int n = 0; n < line.size(); n++) begin
            int c;
            @(negedge CLK);
            RX_IN = line[n];
            PAR_EN = pea[n];
            PAR_TYP = pta[n];
            @(posedge CLK);
            #1;
            c = n + 1;
            if (ev_clr.exists(c)) begin
                m_par = 1'b0;
                m_stp = 1'b0;
            end
            if (ev_par.exists(c)) m_par = ev_par[c];
            if (ev_stp.exists(c)) m_stp = ev_stp[c];
            exp_v = ev_val.exists(c);
            if (exp_v) m_pdata = ev_val[c];
            total++;
            if (data_valid !== exp_v) begin
                bad++;
                $display("FAIL data_valid p=%0d cycle=%0d got=%b want=%b", p, c, data_valid, exp_v);
            end
            total++;
            if (P_DATA !== m_pdata) begin
                bad++;
                $display("FAIL P_DATA p=%0d cycle=%0d got=%h want=%h", p, c, P_DATA, m_pdata);
            end
            total++;
            if (par_err !== m_par) begin
                bad++;
                $display("FAIL par_err p=%0d cycle=%0d got=%b want=%b", p, c, par_err, m_par);
            end
            total++;
            if (stp_err !== m_stp) begin
                bad++;
                $display("FAIL stp_err p=%0d cycle=%0d got=%b want=%b", p, c, stp_err, m_stp);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({P_DATA, data_valid, par_err, stp_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h_%b%b%b want=0", P_DATA, data_valid, par_err, stp_err);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_good_even();
        frame_t q[$];
        q.push_back(good(8'hA5, 1'b1, PAR_EVEN, 0));
        run(8, q);
    endtask

    task automatic test_parity_err();
        frame_t q[$];
        frame_t f;
        f = good(8'hA5, 1'b1, PAR_ODD, 0);
        f.pbit = 1'b0;
        q.push_back(f);
        run(8, q);
    endtask

    task automatic test_glitch();
        frame_t q[$];
        frame_t f;
        f = good(8'h00, 1'b0, PAR_EVEN, 0);
        f.glitch = 3;
        q.push_back(f);
        q.push_back(good(8'h96, 1'b0, PAR_EVEN, 0));
        run(16, q);
    endtask

    task automatic test_stop_err();
        frame_t q[$];
        frame_t f;
        f = good(8'h3C, 1'b0, PAR_EVEN, 0);
        f.sbit = 1'b0;
        q.push_back(f);
        run(8, q);
    endtask

    task automatic test_back_to_back();
        frame_t q[$];
        q.push_back(good(8'h3C, 1'b0, PAR_EVEN, 0));
        q.push_back(good(8'hC3, 1'b0, PAR_EVEN, 0));
        run(16, q);
    endtask

    task automatic test_reset_mid();
        frame_t q[$];
        logic [W-1:0] d;
        q.push_back(good(8'h5A, 1'b0, PAR_EVEN, 2));
        run(32, q);
        d = 8'h55;
        for (int n = 0; n < 32 * 4 + 5; n++) begin
            @(negedge CLK);
            RX_IN = (n < 32) ? 1'b0 : d[n / 32 - 1];
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if ({P_DATA, data_valid, par_err, stp_err} !== '0) begin
                bad++;
                $display("FAIL reset_mid step=%0d got=%h_%b%b%b want=0", k, P_DATA, data_valid, par_err, stp_err);
            end
            @(negedge CLK);
        end
        RST = 1'b1;
        RX_IN = 1'b1;
        m_pdata = '0;
        m_par = 1'b0;
        m_stp = 1'b0;
        repeat (2) @(negedge CLK);
        q.delete();
        q.push_back(good(8'h12, 1'b0, PAR_EVEN, 0));
        run(32, q);
    endtask

    task automatic test_random();
        for (int st = 0; st < 4; st++) begin
            frame_t q[$];
            int p;
            p = 8 << $urandom_range(2);
            for (int i = 0; i < 6; i++) begin
                frame_t f;
                f = good(8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
                         ($urandom_range(2) == 0) ? 0 : int'($urandom_range(5)));
                if ($urandom_range(3) == 0) f.pbit = ~f.pbit;
                if ($urandom_range(4) == 0) f.sbit = 1'b0;
                if ($urandom_range(7) == 0) f.glitch = int'($urandom_range(p / 2 - 1, 1));
                q.push_back(f);
            end
            run(p, q);
        end
    endtask

    initial begin
        test_reset();
        test_good_even();
        test_parity_err();
        test_glitch();
        test_stop_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
